// File: rtl/operand2_imm_encoder_if.sv
// Request/result bundle for the operand2 immediate encoder.
interface operand2_imm_encoder_if;
    logic        start;
    logic [31:0] value_in;
    logic        busy;
    logic        done;
    logic        valid;
    logic        inverted;
    logic [11:0] operand2;
    logic        carry_defined;
    logic        carry_bit;

    modport master (
        output start,
        output value_in,
        input  busy,
        input  done,
        input  valid,
        input  inverted,
        input  operand2,
        input  carry_defined,
        input  carry_bit
    );

    modport slave (
        input  start,
        input  value_in,
        output busy,
        output done,
        output valid,
        output inverted,
        output operand2,
        output carry_defined,
        output carry_bit
    );
endinterface

// File: rtl/operand2_imm_encoder.sv
// Iterative search for an ARM data-processing immediate {rot, imm8} whose
// ROR(imm8, 2*rot) equals the requested constant (or its inverse for MVN).
// One rotation candidate is tested per cycle; lowest rot wins, direct first.
module operand2_imm_encoder #(
    parameter bit ALLOW_INVERT = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    operand2_imm_encoder_if.slave       bus
);

    typedef enum logic [1:0] {
        StIdle,
        StSearch,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] value_q, value_d;
    logic [3:0]  rot_q, rot_d;
    logic        phase_q, phase_d;
    logic        valid_q, valid_d;
    logic        inverted_q, inverted_d;
    logic [11:0] operand2_q, operand2_d;
    logic        carry_defined_q, carry_defined_d;
    logic        carry_bit_q, carry_bit_d;

    logic [31:0] operand;
    logic [5:0]  shamt;
    logic [63:0] doubled;
    logic [31:0] cand;
    logic        hit;

    // Candidate generation: rotate the current operand left by 2*rot.
    always_comb begin
        operand = phase_q ? ~value_q : value_q;
        shamt   = {1'b0, rot_q, 1'b0};
        // Upper half of the shifted concatenation is the 32-bit rotate-left.
        doubled = {operand, operand} << shamt;
        cand    = doubled[63:32];
        hit     = (cand[31:8] == 24'd0);
    end

    // Next-state and result-register logic.
    always_comb begin
        state_d         = state_q;
        value_d         = value_q;
        rot_d           = rot_q;
        phase_d         = phase_q;
        valid_d         = valid_q;
        inverted_d      = inverted_q;
        operand2_d      = operand2_q;
        carry_defined_d = carry_defined_q;
        carry_bit_d     = carry_bit_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    value_d = bus.value_in;
                    rot_d   = 4'd0;
                    phase_d = 1'b0;
                    state_d = StSearch;
                end
            end
            StSearch: begin
                if (hit) begin
                    operand2_d      = {rot_q, cand[7:0]};
                    valid_d         = 1'b1;
                    inverted_d      = phase_q;
                    carry_defined_d = (rot_q != 4'd0);
                    carry_bit_d     = operand[31];
                    state_d         = StDone;
                end else if (rot_q != 4'd15) begin
                    rot_d = rot_q + 4'd1;
                end else if (!phase_q && ALLOW_INVERT) begin
                    phase_d = 1'b1;
                    rot_d   = 4'd0;
                end else begin
                    operand2_d      = 12'd0;
                    valid_d         = 1'b0;
                    inverted_d      = 1'b0;
                    carry_defined_d = 1'b0;
                    carry_bit_d     = 1'b0;
                    state_d         = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and result registers; reset abandons any search in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            value_q         <= 32'd0;
            rot_q           <= 4'd0;
            phase_q         <= 1'b0;
            valid_q         <= 1'b0;
            inverted_q      <= 1'b0;
            operand2_q      <= 12'd0;
            carry_defined_q <= 1'b0;
            carry_bit_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            value_q         <= value_d;
            rot_q           <= rot_d;
            phase_q         <= phase_d;
            valid_q         <= valid_d;
            inverted_q      <= inverted_d;
            operand2_q      <= operand2_d;
            carry_defined_q <= carry_defined_d;
            carry_bit_q     <= carry_bit_d;
        end
    end

    assign bus.busy          = (state_q == StSearch);
    assign bus.done          = (state_q == StDone);
    assign bus.valid         = valid_q;
    assign bus.inverted      = inverted_q;
    assign bus.operand2      = operand2_q;
    assign bus.carry_defined = carry_defined_q;
    assign bus.carry_bit     = carry_bit_q;

endmodule

// File: tb/tb_operand2_imm_encoder.sv
// Directed bench: one encoder with inverse search, one without.
module tb_operand2_imm_encoder;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   lat;
    bit   got;

    operand2_imm_encoder_if ia ();
    operand2_imm_encoder_if ib ();

    operand2_imm_encoder #(.ALLOW_INVERT(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia.slave)
    );

    operand2_imm_encoder #(.ALLOW_INVERT(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one request; poke = cycle to pulse a second start (0xFF),
    // rst_at = cycle to assert reset (-1 disables either).
    task automatic run(input bit sel, input logic [31:0] val, input int poke, input int rst_at);
        @(negedge clk);
        if (sel) begin ib.start = 1'b1; ib.value_in = val; end
        else begin ia.start = 1'b1; ia.value_in = val; end
        @(posedge clk);
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            ia.start = 1'b0;
            ib.start = 1'b0;
            ia.value_in = 32'hDEAD_BEEF;
            ib.value_in = 32'hDEAD_BEEF;
            if (sel ? ib.done : ia.done) begin
                got = 1'b1;
                break;
            end
            if (lat == rst_at) begin
                rst = 1'b1;
                break;
            end
            if (lat == poke) begin
                if (sel) begin ib.start = 1'b1; ib.value_in = 32'hFF; end
                else begin ia.start = 1'b1; ia.value_in = 32'hFF; end
            end
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic chk_res(input string tag, input bit sel, input int exp_lat, input bit v,
                           input bit inv, input logic [11:0] op2, input bit cd, input bit cb);
        chk({tag, "_done"}, {31'd0, got}, 32'd1);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_valid"}, {31'd0, sel ? ib.valid : ia.valid}, {31'd0, v});
        chk({tag, "_inv"}, {31'd0, sel ? ib.inverted : ia.inverted}, {31'd0, inv});
        chk({tag, "_op2"}, {20'd0, sel ? ib.operand2 : ia.operand2}, {20'd0, op2});
        chk({tag, "_cdef"}, {31'd0, sel ? ib.carry_defined : ia.carry_defined}, {31'd0, cd});
        chk({tag, "_cbit"}, {31'd0, sel ? ib.carry_bit : ia.carry_bit}, {31'd0, cb});
    endtask

    initial begin
        total = 0;
        bad = 0;
        ia.start = 1'b0;
        ib.start = 1'b0;
        ia.value_in = 32'd0;
        ib.value_in = 32'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, ia.busy}, 32'd0);
        chk("rst_done", {31'd0, ia.done}, 32'd0);
        chk("rst_op2", {20'd0, ia.operand2}, 32'd0);
        chk("rst_valid", {31'd0, ia.valid}, 32'd0);
        rst = 1'b0;

        run(1'b0, 32'h0000_00FF, -1, -1);
        chk_res("ff", 1'b0, 1, 1'b1, 1'b0, 12'h0FF, 1'b0, 1'b0);
        @(negedge clk);
        chk("ff_done_pulse", {31'd0, ia.done}, 32'd0);
        chk("ff_hold_op2", {20'd0, ia.operand2}, 32'h0FF);

        run(1'b0, 32'hFF00_0000, -1, -1);
        chk_res("ff000000", 1'b0, 5, 1'b1, 1'b0, 12'h4FF, 1'b1, 1'b1);

        run(1'b0, 32'h0000_03FC, 2, -1);
        chk_res("3fc", 1'b0, 16, 1'b1, 1'b0, 12'hFFF, 1'b1, 1'b0);

        run(1'b0, 32'h8000_0001, -1, -1);
        chk_res("80000001", 1'b0, 2, 1'b1, 1'b0, 12'h106, 1'b1, 1'b1);

        run(1'b0, 32'hFFFF_FF00, -1, -1);
        chk_res("inv_ff", 1'b0, 17, 1'b1, 1'b1, 12'h0FF, 1'b0, 1'b0);

        run(1'b0, 32'h0000_0000, -1, -1);
        chk_res("zero", 1'b0, 1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0);

        run(1'b0, 32'h0000_0101, -1, -1);
        chk_res("miss", 1'b0, 32, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);

        run(1'b1, 32'h0000_0101, -1, -1);
        chk_res("b_miss", 1'b1, 16, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);

        run(1'b1, 32'hFFFF_FF00, -1, -1);
        chk_res("b_noinv", 1'b1, 16, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);

        run(1'b1, 32'h0000_3FC0, -1, -1);
        chk_res("b_3fc0", 1'b1, 14, 1'b1, 1'b0, 12'hDFF, 1'b1, 1'b0);

        // Second start during the search must be ignored.
        run(1'b0, 32'h0000_0101, 3, -1);
        chk_res("poke", 1'b0, 32, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);

        run(1'b0, 32'h0000_00FF, -1, -1);
        chk_res("pre_rst", 1'b0, 1, 1'b1, 1'b0, 12'h0FF, 1'b0, 1'b0);

        // Reset mid-search: outputs clear without a clock edge.
        run(1'b0, 32'h0000_0101, -1, 5);
        #1;
        chk("mid_rst_got", {31'd0, got}, 32'd0);
        chk("mid_rst_busy", {31'd0, ia.busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, ia.valid}, 32'd0);
        chk("mid_rst_op2", {20'd0, ia.operand2}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ia.done) got = 1'b1;
        end
        chk("mid_rst_nodone", {31'd0, got}, 32'd0);

        run(1'b0, 32'h0000_00FF, -1, -1);
        chk_res("post_rst", 1'b0, 1, 1'b1, 1'b0, 12'h0FF, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
